// File: rtl/dbg_probe_capture_pkg.sv
// Shared mode and capture-state encodings for the LED debug probe capture block.
package dbg_probe_capture_pkg;

   typedef enum logic [1:0] {
      MODE_LIVE   = 2'b00,
      MODE_RECORD = 2'b01,
      MODE_PLAY   = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      CAP_IDLE     = 2'd0,
      CAP_ARMED    = 2'd1,
      CAP_POSTTRIG = 2'd2,
      CAP_DONE     = 2'd3
   } cap_state_e;

endpackage

// File: rtl/dbg_ring_buf.sv
// Capture storage: register array with one synchronous write port and one asynchronous read port.
module dbg_ring_buf #(
   parameter int DEPTH = 16,
   parameter int W     = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dbg_probe_capture.sv
// LED debug mux with live, freeze, trigger-qualified record and playback modes.
module dbg_probe_capture
   import dbg_probe_capture_pkg::*;
#(
   parameter int CH_NUM = 64,
   parameter int CH_W   = 16,
   parameter int LED_W  = 16,
   parameter int SEL_W  = 8,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4,
   parameter int POST   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH_NUM*CH_W-1:0]   probe_bus,
   input  logic [15:0]              sw,
   input  logic                     sample_en,
   input  logic                     trig_in,
   output logic [LED_W-1:0]         led_data,
   output logic [1:0]               cap_state,
   output logic [PTR_W:0]           cap_count,
   output logic [PTR_W-1:0]         trig_pos
);

   localparam int              IDX_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [SEL_W:0]  CH_LIMIT  = (SEL_W+1)'(CH_NUM);
   localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]  POST_LAST = (PTR_W+1)'(POST - 1);

   logic [CH_W-1:0]  chan [CH_NUM];
   mode_e            mode;
   mode_e            mode_q;
   cap_state_e       state_q;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] cap_sel;
   logic [SEL_W-1:0] rec_sel;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] trig_wr;
   logic [PTR_W-1:0] oldest;
   logic [PTR_W-1:0] raddr;
   logic [PTR_W:0]   post_cnt;
   logic [CH_W-1:0]  rec_val;
   logic [CH_W-1:0]  rdata;
   logic [LED_W-1:0] live_val;
   logic [LED_W-1:0] play_val;
   logic [LED_W-1:0] frz;
   logic             entering;
   logic             we;
   logic             unused_sw;

   genvar k;
   generate
      for (k = 0; k < CH_NUM; k++) begin : g_chan
         assign chan[k] = probe_bus[k*CH_W +: CH_W];
      end
   endgenerate

   assign mode      = mode_e'(sw[7:6]);
   assign sel       = sw[15:8];
   assign unused_sw = ^sw[5:4];

   // The first RECORD cycle latches a new channel, so the display follows the switches right away.
   assign entering = (mode == MODE_RECORD) && (state_q == CAP_IDLE);
   assign rec_sel  = entering ? sel : cap_sel;
   assign rec_val  = ({1'b0, rec_sel} < CH_LIMIT) ? chan[rec_sel[IDX_W-1:0]] : '0;
   assign live_val = ({1'b0, sel} < CH_LIMIT) ? LED_W'(chan[sel[IDX_W-1:0]]) : LED_W'(sw);

   assign we = (mode == MODE_RECORD) && sample_en &&
               ((state_q == CAP_ARMED) || (state_q == CAP_POSTTRIG));

   // Playback indices count from the oldest valid sample, which trails the write pointer by the fill level.
   assign oldest   = wr_ptr - cap_count[PTR_W-1:0];
   assign raddr    = oldest + sw[PTR_W-1:0];
   assign trig_pos = trig_wr - oldest;
   assign play_val = ({1'b0, sw[3:0]} >= 5'(cap_count)) ? '0 : LED_W'(rdata);

   assign cap_state = state_q;

   dbg_ring_buf #(
      .DEPTH (DEPTH),
      .W     (CH_W),
      .PTR_W (PTR_W)
   ) u_ring_buf (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (rec_val),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_data  <= '0;
         state_q   <= CAP_IDLE;
         cap_count <= '0;
         wr_ptr    <= '0;
         post_cnt  <= '0;
         cap_sel   <= '0;
         trig_wr   <= '0;
         frz       <= '0;
         mode_q    <= MODE_LIVE;
      end else begin
         mode_q <= mode;
         if (mode == MODE_RECORD) begin
            case (state_q)
               CAP_IDLE: begin
                  state_q   <= CAP_ARMED;
                  cap_sel   <= sel;
                  wr_ptr    <= '0;
                  cap_count <= '0;
                  post_cnt  <= '0;
                  trig_wr   <= '0;
               end
               CAP_ARMED: begin
                  if (sample_en) begin
                     wr_ptr <= wr_ptr + 1'b1;
                     if (cap_count != DEPTH_CNT) cap_count <= cap_count + 1'b1;
                     if (trig_in) begin
                        trig_wr  <= wr_ptr;
                        post_cnt <= (PTR_W+1)'(1);
                        state_q  <= (POST == 1) ? CAP_DONE : CAP_POSTTRIG;
                     end
                  end
               end
               CAP_POSTTRIG: begin
                  if (sample_en) begin
                     wr_ptr   <= wr_ptr + 1'b1;
                     post_cnt <= post_cnt + 1'b1;
                     if (cap_count != DEPTH_CNT) cap_count <= cap_count + 1'b1;
                     if (post_cnt == POST_LAST) state_q <= CAP_DONE;
                  end
               end
               default: begin
               end
            endcase
         end else begin
            state_q <= CAP_IDLE;
         end

         case (mode)
            MODE_LIVE:   led_data <= live_val;
            MODE_FREEZE: begin
               if (mode_q != MODE_FREEZE) begin
                  frz      <= live_val;
                  led_data <= live_val;
               end else begin
                  led_data <= frz;
               end
            end
            MODE_RECORD: led_data <= LED_W'(rec_val);
            default:     led_data <= play_val;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_probe_capture.sv
// Self-checking bench: queue-based capture model plus directed and randomized switch/probe stimulus.
module tb_dbg_probe_capture;

   localparam logic [1:0] LIVE = 2'd0;
   localparam logic [1:0] REC  = 2'd1;
   localparam logic [1:0] PLAY = 2'd2;
   localparam logic [1:0] FRZ  = 2'd3;
   localparam int         POST = 8;

   logic          clk;
   logic          rst;
   logic [1023:0] probe_bus;
   logic [15:0]   sw;
   logic          sample_en;
   logic          trig_in;
   logic [15:0]   led_data;
   logic [1:0]    cap_state;
   logic [4:0]    cap_count;
   logic [3:0]    trig_pos;

   int checks;
   int failures;

   // Model state: captured samples oldest-first, plus absolute sample numbering since arming.
   logic [15:0] m_q [$];
   logic [15:0] m_led;
   logic [15:0] m_frz;
   logic [7:0]  m_capsel;
   logic [1:0]  m_prev;
   int          m_state;
   int          m_total;
   int          m_trig;
   int          m_post;

   dbg_probe_capture dut (
      .clk       (clk),
      .rst       (rst),
      .probe_bus (probe_bus),
      .sw        (sw),
      .sample_en (sample_en),
      .trig_in   (trig_in),
      .led_data  (led_data),
      .cap_state (cap_state),
      .cap_count (cap_count),
      .trig_pos  (trig_pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] chanOf(input logic [7:0] s);
      if (s < 8'd64) return probe_bus[int'(s)*16 +: 16];
      return 16'h0000;
   endfunction

   function automatic logic [15:0] mk(input logic [7:0] s, input logic [1:0] m, input logic [3:0] idx);
      return {s, m, 2'b00, idx};
   endfunction

   function automatic int expTrigPos();
      return ((m_trig - m_total + m_q.size()) % 16 + 16) % 16;
   endfunction

   task automatic modelReset();
      m_q.delete();
      m_led    = '0;
      m_frz    = '0;
      m_capsel = '0;
      m_prev   = LIVE;
      m_state  = 0;
      m_total  = 0;
      m_trig   = 0;
      m_post   = 0;
   endtask

   task automatic modelStep();
      logic [1:0]  mode;
      logic [7:0]  sel;
      logic [15:0] live;
      int          idx;
      mode = sw[7:6];
      sel  = sw[15:8];
      live = (sel < 8'd64) ? chanOf(sel) : sw;
      case (mode)
         LIVE: m_led = live;
         FRZ: begin
            if (m_prev != FRZ) begin
               m_frz = live;
               m_led = live;
            end else begin
               m_led = m_frz;
            end
         end
         PLAY: begin
            idx   = int'(sw[3:0]);
            m_led = (idx < m_q.size()) ? m_q[idx] : 16'h0000;
         end
         default: begin
            if (m_state == 0) begin
               m_led    = chanOf(sel);
               m_capsel = sel;
               m_q.delete();
               m_total  = 0;
               m_trig   = 0;
               m_post   = 0;
               m_state  = 1;
            end else begin
               m_led = chanOf(m_capsel);
               if (sample_en && (m_state == 1 || m_state == 2)) begin
                  m_q.push_back(chanOf(m_capsel));
                  if (m_q.size() > 16) void'(m_q.pop_front());
                  if (m_state == 1 && trig_in) begin
                     m_trig  = m_total;
                     m_post  = 1;
                     m_state = (POST == 1) ? 3 : 2;
                  end else if (m_state == 2) begin
                     m_post++;
                     if (m_post == POST) m_state = 3;
                  end
                  m_total++;
               end
            end
         end
      endcase
      if (mode != REC) m_state = 0;
      m_prev = mode;
   endtask

   // Model advances on every active edge with reset released, then the DUT is compared 1 ns later.
   always @(posedge clk) begin
      if (rst) begin
         modelStep();
         #1;
         checkOutput("led_data",  32'(led_data),  32'(m_led));
         checkOutput("cap_state", 32'(cap_state), 32'(m_state));
         checkOutput("cap_count", 32'(cap_count), 32'(m_q.size()));
         checkOutput("trig_pos",  32'(trig_pos),  32'(expTrigPos()));
      end
   end

   task automatic applyStimulus(input logic [15:0] s, input logic se, input logic tg);
      @(negedge clk);
      sw        = s;
      sample_en = se;
      trig_in   = tg;
   endtask

   task automatic setChan(input int k, input logic [15:0] v);
      probe_bus[k*16 +: 16] = v;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic assertReset();
      rst = 1'b0;
      modelReset();
      #1;
      checkOutput("rst_led",   32'(led_data),  32'h0);
      checkOutput("rst_state", 32'(cap_state), 32'h0);
      checkOutput("rst_count", 32'(cap_count), 32'h0);
      checkOutput("rst_trig",  32'(trig_pos),  32'h0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      sw        = '0;
      sample_en = 1'b0;
      trig_in   = 1'b0;
      probe_bus = '0;
      #2;
      assertReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Live select and out-of-range select.
      applyStimulus(mk(8'h05, LIVE, 4'd0), 1'b0, 1'b0);
      setChan(5, 16'hBEEF);
      settle();
      checkOutput("live_ch5", 32'(led_data), 32'hBEEF);
      applyStimulus(16'hFF00, 1'b0, 1'b0);
      settle();
      checkOutput("live_oor", 32'(led_data), 32'hFF00);

      // Freeze holds the value seen on entry.
      applyStimulus(mk(8'h05, LIVE, 4'd0), 1'b0, 1'b0);
      setChan(5, 16'h1234);
      settle();
      applyStimulus(mk(8'h05, FRZ, 4'd0), 1'b0, 1'b0);
      settle();
      checkOutput("frz_entry", 32'(led_data), 32'h1234);
      applyStimulus(mk(8'h05, FRZ, 4'd0), 1'b0, 1'b0);
      setChan(5, 16'h5678);
      settle();
      checkOutput("frz_hold", 32'(led_data), 32'h1234);
      applyStimulus(mk(8'h05, LIVE, 4'd0), 1'b0, 1'b0);
      settle();
      checkOutput("frz_exit", 32'(led_data), 32'h5678);

      // Wrapped record: 30 samples, trigger on sample 20.
      applyStimulus(mk(8'h05, REC, 4'd0), 1'b0, 1'b0);
      for (int n = 0; n < 30; n++) begin
         applyStimulus(mk(8'h05, REC, 4'd0), 1'b1, n == 20);
         setChan(5, 16'(n));
      end
      settle();
      checkOutput("rec1_state", 32'(cap_state), 32'd3);
      checkOutput("rec1_count", 32'(cap_count), 32'd16);
      checkOutput("rec1_trig",  32'(trig_pos),  32'd8);
      applyStimulus(mk(8'h05, PLAY, 4'd0), 1'b0, 1'b0);
      settle();
      checkOutput("rec1_idx0", 32'(led_data), 32'd12);
      checkOutput("rec1_idle", 32'(cap_state), 32'd0);
      applyStimulus(mk(8'h05, PLAY, 4'd8), 1'b0, 1'b0);
      settle();
      checkOutput("rec1_idx8", 32'(led_data), 32'd20);
      applyStimulus(mk(8'h05, PLAY, 4'd15), 1'b0, 1'b0);
      settle();
      checkOutput("rec1_idx15", 32'(led_data), 32'd27);

      // Short record left mid-POSTTRIG.
      applyStimulus(mk(8'h05, REC, 4'd0), 1'b0, 1'b0);
      for (int n = 0; n < 8; n++) begin
         applyStimulus(mk(8'h05, REC, 4'd0), 1'b1, n == 3);
         setChan(5, 16'h0100 + 16'(n));
      end
      settle();
      checkOutput("rec2_state", 32'(cap_state), 32'd2);
      checkOutput("rec2_count", 32'(cap_count), 32'd8);
      checkOutput("rec2_trig",  32'(trig_pos),  32'd3);
      applyStimulus(mk(8'h05, PLAY, 4'd3), 1'b0, 1'b0);
      settle();
      checkOutput("rec2_idx3", 32'(led_data), 32'h0103);
      for (int i = 8; i < 16; i++) begin
         applyStimulus(mk(8'h05, PLAY, 4'(i)), 1'b0, 1'b0);
         settle();
         checkOutput("rec2_empty", 32'(led_data), 32'h0);
      end

      // Trigger held high: only the first is taken, and DONE ignores further samples.
      applyStimulus(mk(8'h05, REC, 4'd0), 1'b0, 1'b0);
      for (int n = 0; n < 12; n++) begin
         applyStimulus(mk(8'h05, REC, 4'd0), 1'b1, 1'b1);
         setChan(5, 16'h0200 + 16'(n));
      end
      settle();
      checkOutput("rec3_state", 32'(cap_state), 32'd3);
      checkOutput("rec3_count", 32'(cap_count), 32'd8);
      checkOutput("rec3_trig",  32'(trig_pos),  32'd0);
      applyStimulus(mk(8'h05, PLAY, 4'd7), 1'b0, 1'b0);
      settle();
      checkOutput("rec3_idx7", 32'(led_data), 32'h0207);

      // Asynchronous reset while in POSTTRIG.
      applyStimulus(mk(8'h05, REC, 4'd0), 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) begin
         applyStimulus(mk(8'h05, REC, 4'd0), 1'b1, n == 2);
         setChan(5, 16'h0300 + 16'(n));
      end
      settle();
      checkOutput("rec4_state", 32'(cap_state), 32'd2);
      assertReset();
      @(negedge clk);
      rst = 1'b1;

      // Randomized modes, selects, strobes and probe data.
      begin
         logic [1:0] rmode;
         int         run;
         run   = 0;
         rmode = LIVE;
         for (int c = 0; c < 2500; c++) begin
            logic [7:0] rsel;
            if (run == 0) begin
               rmode = 2'($urandom_range(0, 3));
               run   = $urandom_range(1, 40);
            end
            run--;
            rsel = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            applyStimulus(mk(rsel, rmode, 4'($urandom_range(0, 15))),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            for (int k = 0; k < 64; k++) setChan(k, 16'($urandom));
         end
      end

      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
